// File: rtl/ultra_sonic_ctrl.sv
// ultra_sonic_ctrl: HC-SR04 measurement sequencer covering trigger, echo supervision and us/cm conversion.
// Build option ULTRA_SONIC_FILTER_EN makes dist_cm a (3*old + sample)/4 IIR-filtered value.
module ultra_sonic_ctrl #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int TRIG_US      = 15,
    parameter int ECHO_WAIT_US = 30000,
    parameter int ECHO_MAX_US  = 25000,
    parameter int GAP_US       = 60000,
    parameter int CM_DIV       = 58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cont,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] echo_us,
    output logic [9:0]  dist_cm
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam int SW = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

    localparam logic [PW-1:0] PRESC_END  = PW'(CLK_FREQ_MHZ - 1);
    localparam logic [PW-1:0] PRESC_RISE = (CLK_FREQ_MHZ > 1) ? PW'(1) : PW'(0);
    localparam logic [SW-1:0] SUB_END    = SW'(CM_DIV - 1);
    localparam logic [15:0]   TRIG_END   = 16'(TRIG_US - 1);
    localparam logic [15:0]   WAIT_END   = 16'(ECHO_WAIT_US - 1);
    localparam logic [15:0]   MAX_END    = 16'(ECHO_MAX_US - 1);
    localparam logic [15:0]   GAP_END    = 16'(GAP_US - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic [9:0]      cm_q, cm_d;
    logic            echo_meta_q, echo_meta_d;
    logic            echo_s_q, echo_s_d;
    logic            trig_q, trig_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     echo_us_q, echo_us_d;
    logic [9:0]      dist_q, dist_d;
    logic            us_tick;
`ifdef ULTRA_SONIC_FILTER_EN
    logic            filt_vld_q, filt_vld_d;
`endif

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

`ifdef ULTRA_SONIC_FILTER_EN
    function automatic logic [9:0] iir_step(input logic [9:0] old, input logic [9:0] smp);
        logic [11:0] acc;
        acc = {2'b00, old} + {1'b0, old, 1'b0} + {2'b00, smp};
        return 10'(acc >> 2);
    endfunction
`endif

    assign us_tick = (presc_q == PRESC_END);

    always_comb begin
        state_d     = state_q;
        presc_d     = us_tick ? '0 : presc_q + 1'b1;
        cnt_d       = us_tick ? sat_inc16(cnt_q) : cnt_q;
        sub_d       = sub_q;
        cm_d        = cm_q;
        echo_meta_d = echo;
        echo_s_d    = echo_meta_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        echo_us_d   = echo_us_q;
        dist_d      = dist_q;
`ifdef ULTRA_SONIC_FILTER_EN
        filt_vld_d  = filt_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (us_tick && cnt_q == TRIG_END) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (echo_s_q) begin
                    state_d = S_MEASURE;
                end else if (us_tick && cnt_q == WAIT_END) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_MEASURE: begin
                if (us_tick) begin
                    // cm follows us/CM_DIV through a wrapping sub-counter instead of a divider
                    sub_d = (sub_q == SUB_END) ? '0 : sub_q + 1'b1;
                    if (sub_q == SUB_END) cm_d = sat_inc10(cm_q);
                end
                if (!echo_s_q) begin
                    echo_us_d = cnt_q;
`ifdef ULTRA_SONIC_FILTER_EN
                    dist_d     = filt_vld_q ? iir_step(dist_q, cm_q) : cm_q;
                    filt_vld_d = 1'b1;
`else
                    dist_d     = cm_q;
`endif
                    done_d    = 1'b1;
                    state_d   = S_GAP;
                end else if (us_tick && cnt_q == MAX_END) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (us_tick && cnt_q == GAP_END) state_d = cont ? S_TRIG : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || state_d == S_IDLE) begin
            presc_d = '0;
            cnt_d   = '0;
            sub_d   = '0;
            cm_d    = '0;
            // the cycle that saw the rise already belongs to the echo width
            if (state_d == S_MEASURE) presc_d = PRESC_RISE;
        end

        if (state_d == S_TRIG) timeout_d = 1'b0;
        trig_d = (state_d == S_TRIG);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            cnt_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            echo_us_q   <= '0;
            dist_q      <= '0;
`ifdef ULTRA_SONIC_FILTER_EN
            filt_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            echo_meta_q <= echo_meta_d;
            echo_s_q    <= echo_s_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            echo_us_q   <= echo_us_d;
            dist_q      <= dist_d;
`ifdef ULTRA_SONIC_FILTER_EN
            filt_vld_q  <= filt_vld_d;
`endif
        end
    end

    assign trig    = trig_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign echo_us = echo_us_q;
    assign dist_cm = dist_q;

endmodule

// File: doc/ultra_sonic_ctrl.md
# ultra_sonic_ctrl

Measurement controller for the HC-SR04 ultrasonic ranging path. Schedules single-shot or continuous measurements, generates the trigger pulse, supervises the echo with timeouts, and converts echo width to microseconds and centimetres. It sits between the user controls (button and switch logic) and the distance display/FND path, and it replaces ad-hoc trigger generation with one sequenced owner of the sensor.

## Interface
- CLK_FREQ_MHZ, 100, system clock in MHz; used for the 1 us prescaler
- TRIG_US, 15, trigger pulse width in us
- ECHO_WAIT_US, 30000, maximum wait for echo rise after trigger, in us
- ECHO_MAX_US, 25000, maximum echo high time in us, about 431 cm
- GAP_US, 60000, mandatory idle time between measurements, in us
- CM_DIV, 58, us of echo per cm
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cont  in  1  continuous mode; level-sampled at the end of GAP
- echo  in  1  asynchronous sensor echo; 2-FF synchronised internally
- trig  out  1  sensor trigger pin
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a measurement completes or times out
- timeout  out  1  set on timeout; cleared at the next TRIG entry
- echo_us  out  16  last valid echo width in us
- dist_cm  out  10  last valid distance in cm

## Operation
- States: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- Prescaler: counts 0..CLK_FREQ_MHZ-1. It clears on every state entry, so us_tick fires on the CLK_FREQ_MHZ-th cycle in the state. All us counters advance only on us_tick.
- IDLE -> TRIG on start.
- TRIG: trig=1 and timeout clears. After TRIG_US ticks -> WAIT_RISE.
- WAIT_RISE: echo_s is the synchronised echo.
  - echo_s=1 -> MEASURE, with the us and cm counters cleared.
  - Wait counter reaches ECHO_WAIT_US -> timeout=1, done=1, go to GAP.
- MEASURE: each us_tick increments the us counter and a mod-CM_DIV sub-counter. Each time the sub-counter wraps, the cm counter increments, so cm = floor(us/CM_DIV) with no divider.
  - echo_s=0 -> latch echo_us and dist_cm, done=1, go to GAP.
  - us counter reaches ECHO_MAX_US before the fall -> timeout=1, done=1, go to GAP; outputs keep their old values.
- GAP: after GAP_US ticks -> TRIG if cont=1, otherwise IDLE. GAP is never skipped, including after a timeout.
- start outside IDLE is ignored; it is not queued.
- If start and cont are both high in IDLE, start alone launches the measurement. cont only governs re-triggering after GAP.
- Dropping cont mid-cycle lets the current measurement and GAP finish, then the block returns to IDLE.
- Simultaneous echo_s fall and ECHO_MAX_US reached: the fall wins and the result is valid.
- Counters saturate. No wrap-around is possible because ECHO_MAX_US < 2^16 and the cm result < 2^10.

## Timing
- Reset values: trig=0, busy=0, done=0, timeout=0, echo_us=0, dist_cm=0, state=IDLE, all counters 0.
- Reset mid-operation: on the reset edge, trig drops and all outputs return to reset values the next cycle.
- start -> trig=1: 1 cycle. trig is high exactly TRIG_US*CLK_FREQ_MHZ cycles.
- echo latency: 2 cycles of synchroniser before any decision on echo.
- echo fall -> done: 3 cycles (2 sync plus 1 register).
- echo_us and dist_cm update in the same cycle done asserts and are stable until the next done.
- Echo resolution: 1 us; partial microseconds are truncated.
- trig, busy and done are registered outputs.

## Configuration
- ULTRA_SONIC_FILTER_EN defined: dist_cm is an IIR-filtered value, new = (3*old + sample) >> 2, computed in 12 bits.
  - The first valid sample after reset loads directly.
  - Timeouts do not update the filter.
  - echo_us stays raw.
  - The filter adds no latency: the value is computed combinationally at latch time.
- Not defined: dist_cm is the raw latched sample.

## Test plan
- Single shot, echo high 580 us after a 200 us rise delay -> trig high 1500 cycles, done once, echo_us=580, dist_cm=10, timeout=0, busy until GAP ends.
- Echo never rises -> timeout=1 and done at ECHO_WAIT_US after trig falls; echo_us and dist_cm unchanged; block returns to IDLE after GAP.
- Echo held high -> timeout at 25000 us of echo; outputs unchanged; next start re-triggers and clears timeout.
- cont=1 with echoes of 1160 us -> repeated measurements spaced by TRIG + echo + GAP; each gives dist_cm=20. Dropping cont gives IDLE after the current GAP.
- start pulsed in MEASURE is ignored. reset=0 in MEASURE -> trig=0, busy=0, dist_cm=0 the next cycle.
- With ULTRA_SONIC_FILTER_EN, samples of 10 cm then 20 cm -> dist_cm 10 then 12. Without the macro -> 10 then 20.
